// File: rtl/video_pkg.sv
// Shared video definitions: output modes, RGB332 field layout and the readback expander.
package video_pkg;

  localparam int unsigned ChanW = 8;

  typedef enum logic [1:0] {
    ModeLive     = 2'd0,
    ModeReadback = 2'd1,
    ModeBlack    = 2'd2,
    ModeRsvd     = 2'd3
  } mode_e;

  localparam int unsigned Rgb332RLsb = 5;
  localparam int unsigned Rgb332GLsb = 2;
  localparam int unsigned Rgb332BLsb = 0;

  // Bit replication keeps full-scale codes at 8'hFF and zero at 8'h00.
  function automatic logic [3*ChanW-1:0] expand_rgb332(input logic [7:0] w);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = w[Rgb332RLsb +: 3];
    g = w[Rgb332GLsb +: 3];
    b = w[Rgb332BLsb +: 2];
    return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register for timing strobes; every stage resets to ResetVal.
module sync_delay_line #(
  parameter int unsigned       Width    = 3,
  parameter int unsigned       Depth    = 4,
  parameter logic [Width-1:0]  ResetVal = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Depth-1:0][Width-1:0] dly_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dly_q <= {Depth{ResetVal}};
    end else begin
      dly_q[0] <= d_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign q_o = dly_q[Depth-1];

endmodule

// File: rtl/pixel_compositor.sv
// Output stage: priority overlays with colour key, RGB332 readback or black, frame-latched
// settings. Define PIXEL_COMP_ALPHA_EN to blend layer 0 50/50 instead of replacing.
module pixel_compositor
  import video_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned PIX_W      = 24,
  parameter int unsigned SYNC_DLY   = 44
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        hsync,
  input  logic                        vsync,
  input  logic                        blank,
  input  logic [PIX_W-1:0]            base_pixel,
  input  logic [NUM_LAYERS*PIX_W-1:0] layer_pixel,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  input  logic [PIX_W-1:0]            key_color,
  input  logic [1:0]                  mode_req,
  input  logic [7:0]                  fb_dout,
  input  logic                        in_display,
  output logic [PIX_W-1:0]            pixel_out,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        blank_out,
  output logic                        frame_done,
  output logic [1:0]                  mode_act
);

`ifdef PIXEL_COMP_ALPHA_EN
  localparam int FirstLayer = 1;
`else
  localparam int FirstLayer = 0;
`endif

  // Timing is {hsync, vsync, blank}; tim_a lines up with the pixel inputs.
  logic [2:0] tim_a, tim_s1_q, tim_out_q;
  logic       frame_done_q;
  logic       vs_fall;

  sync_delay_line #(
    .Width    (3),
    .Depth    (SYNC_DLY - 2),
    .ResetVal (3'b111)
  ) u_sync_dly (
    .clk   (clk),
    .reset (reset),
    .d_i   ({hsync, vsync, blank}),
    .q_o   (tim_a)
  );

  assign vs_fall = !tim_a[1] && tim_s1_q[1];

  mode_e                 mode_act_q, mode_act_d, mode_s1_q;
  logic [NUM_LAYERS-1:0] layer_en_act_q, layer_en_act_d;
  logic [PIX_W-1:0]      live_d, live_q, rb_d, rb_q, live_mix, pix_d, pix_q;

  always_comb begin
    mode_act_d     = mode_act_q;
    layer_en_act_d = layer_en_act_q;
    if (vs_fall) begin
      mode_act_d     = mode_e'(mode_req);
      layer_en_act_d = layer_en;
    end
  end

  // Walk from lowest to highest priority so the lowest-index opaque layer lands last.
  always_comb begin
    live_d = base_pixel;
    for (int k = int'(NUM_LAYERS) - 1; k >= FirstLayer; k--) begin
      if (layer_en_act_q[k] && (layer_pixel[k*PIX_W +: PIX_W] != key_color)) begin
        live_d = layer_pixel[k*PIX_W +: PIX_W];
      end
    end
  end

  assign rb_d = in_display ? PIX_W'(expand_rgb332(fb_dout)) : '1;

`ifdef PIXEL_COMP_ALPHA_EN
  logic             l0_opaque_q;
  logic [PIX_W-1:0] l0_pix_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l0_opaque_q <= 1'b0;
      l0_pix_q    <= '0;
    end else begin
      l0_opaque_q <= layer_en_act_q[0] && (layer_pixel[PIX_W-1:0] != key_color);
      l0_pix_q    <= layer_pixel[PIX_W-1:0];
    end
  end

  always_comb begin
    logic [ChanW:0] sum;
    sum      = '0;
    live_mix = live_q;
    for (int c = 0; c < 3; c++) begin
      sum = {1'b0, l0_pix_q[c*ChanW +: ChanW]} + {1'b0, live_q[c*ChanW +: ChanW]};
      if (l0_opaque_q) live_mix[c*ChanW +: ChanW] = sum[ChanW:1];
    end
  end
`else
  assign live_mix = live_q;
`endif

  always_comb begin
    case (mode_s1_q)
      ModeReadback: pix_d = rb_q;
      ModeBlack:    pix_d = '0;
      default:      pix_d = live_mix;
    endcase
    if (tim_s1_q[0]) pix_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tim_s1_q       <= 3'b111;
      tim_out_q      <= 3'b111;
      frame_done_q   <= 1'b0;
      mode_act_q     <= ModeLive;
      layer_en_act_q <= '0;
      mode_s1_q      <= ModeLive;
      live_q         <= '0;
      rb_q           <= '0;
      pix_q          <= '0;
    end else begin
      tim_s1_q       <= tim_a;
      tim_out_q      <= tim_s1_q;
      frame_done_q   <= !tim_s1_q[1] && tim_out_q[1];
      mode_act_q     <= mode_act_d;
      layer_en_act_q <= layer_en_act_d;
      mode_s1_q      <= mode_act_q;
      live_q         <= live_d;
      rb_q           <= rb_d;
      pix_q          <= pix_d;
    end
  end

  assign pixel_out  = pix_q;
  assign hsync_out  = tim_out_q[2];
  assign vsync_out  = tim_out_q[1];
  assign blank_out  = tim_out_q[0];
  assign frame_done = frame_done_q;
  assign mode_act   = mode_act_q;

endmodule
